hack_exec_ctrl: RTL

Multicycle execute/control stage that sits directly upstream of the Hack `ALU` and also consumes its result. It accepts one 16-bit Hack instruction at a time over a valid/ready handshake and holds the A, D and PC registers. It drives the ALU operand and control ports, captures `out`/`zr`/`ng`, then performs register/memory writeback and the jump decision.

---
 rtl/hack_exec_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hack_exec_ctrl.sv
// hack_exec_ctrl -- multicycle execute/control stage for the Hack CPU.
//
// Holds the architectural A, D and PC registers and takes one 16-bit Hack
// instruction at a time over a valid/ready handshake. A-instructions complete
// on the accept edge. C-instructions are latched into ir, then the external
// ALU is driven from ir, its result and flags are captured, and finally the
// register/memory writeback and the jump decision happen on the WB exit edge.
//
// Optional feature: define HACK_MEM_WAIT_EN to add an MREAD wait state for
// C-instructions that read M (ir[12]==1). This gives synchronous memory one
// cycle after addressM to return data, which is then sampled in EXEC.
//
// Parameters:
//   RESET_PC     PC value loaded on reset
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   instr_valid  instruction on instr is offered
//   instr        Hack instruction word
//   instr_ready  block can accept an instruction (IDLE only)
//   inM          memory read data for addressM
//   alu_x/alu_y  ALU operands (D and A-or-M)
//   alu_zx..no   ALU control bits, straight from ir[11:6]
//   alu_out      ALU result; alu_zr / alu_ng its flags
//   outM         memory write data (captured result)
//   writeM       memory write strobe, one cycle in WB when ir[3]
//   addressM     A[14:0]
//   pc           address of the next instruction

module hack_exec_ctrl #(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic [15:0] inM,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [15:0] outM,
    output logic        writeM,
    output logic [14:0] addressM,
    output logic [14:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2,
        MREAD = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] ir_reg;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [14:0] pc_reg;
    logic [15:0] res_reg;
    logic        res_zr_reg;
    logic        res_ng_reg;

    logic        accept;
    logic        jump;
    logic [14:0] pc_inc;

    // Bits 14:13 of a C-instruction carry no meaning; ir[15] is always 1
    // once latched, so it is never consulted.
    logic        unused_bits;
    assign unused_bits = ^{instr[14:13], ir_reg[15:13]};

    assign accept      = instr_valid && (state_reg == IDLE);
    assign instr_ready = (state_reg == IDLE);
    assign pc_inc      = pc_reg + 15'd1;   // 15-bit wrap is intentional

    // ALU is driven from ir in every state; after reset ir==0 so all
    // control bits read as 0.
    assign alu_x = d_reg;
    assign alu_y = ir_reg[12] ? inM : a_reg;
    assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_reg[11:6];

    assign outM     = res_reg;
    assign writeM   = (state_reg == WB) && ir_reg[3];
    // addressM keeps showing the old A through WB, so AM= writes go to
    // the pre-instruction address.
    assign addressM = a_reg[14:0];
    assign pc       = pc_reg;

    assign jump = (ir_reg[2] & res_ng_reg)
                | (ir_reg[1] & res_zr_reg)
                | (ir_reg[0] & ~res_zr_reg & ~res_ng_reg);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && instr[15]) begin
`ifdef HACK_MEM_WAIT_EN
                    state_next = instr[12] ? MREAD : EXEC;
`else
                    state_next = EXEC;
`endif
                end
            end
            MREAD:   state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg     <= 16'd0;
            a_reg      <= 16'd0;
            d_reg      <= 16'd0;
            pc_reg     <= RESET_PC;
            res_reg    <= 16'd0;
            res_zr_reg <= 1'b0;
            res_ng_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!instr[15]) begin
                            a_reg  <= {1'b0, instr[14:0]};
                            pc_reg <= pc_inc;
                        end else begin
                            ir_reg <= instr;
                        end
                    end
                end
                EXEC: begin
                    res_reg    <= alu_out;
                    res_zr_reg <= alu_zr;
                    res_ng_reg <= alu_ng;
                end
                WB: begin
                    if (ir_reg[5]) begin
                        a_reg <= res_reg;
                    end
                    if (ir_reg[4]) begin
                        d_reg <= res_reg;
                    end
                    // Jump target is A before this instruction's writeback.
                    pc_reg <= jump ? a_reg[14:0] : pc_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
